// File: rtl/dsi_lanes_distributor_pkg.sv
// Shared types and constants for the DSI HS lane distributor.
package dsi_lanes_pkg;

  localparam int MAX_LANES = 4;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Mask of n ones, LSB first; n ranges over 0..MAX_LANES.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [2:0] n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dsi_lanes_distributor_if.sv
// Word-in / lanes-out bundle between the bonder, the distributor and the per-lane serializers.
interface dsi_lanes_distributor_if;
  logic [1:0]  lanes_number;
  logic [31:0] in_data;
  logic        in_ready;
  logic        in_read;
  logic        lanes_ready;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic        hs_active;

  modport slave (
    input  lanes_number, in_data, in_ready, lanes_ready,
    output in_read, lane_data, lane_valid, hs_active
  );

  modport master (
    output lanes_number, in_data, in_ready, lanes_ready,
    input  in_read, lane_data, lane_valid, hs_active
  );
endinterface

// File: rtl/dsi_lanes_distributor_lanes_byte_buffer.sv
// Byte shift buffer: pops pop_n head bytes and appends a 4-byte word after the remainder in one clock.
// Head bytes are visible combinationally; the caller guarantees count never overflows DEPTH.
module lanes_byte_buffer
  import dsi_lanes_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [MAX_LANES*BYTE_W-1:0]   push_data,
  input  logic [2:0]                    pop_n,
  output logic [MAX_LANES*BYTE_W-1:0]   head,
  output logic [CNT_W-1:0]              count
);

  logic [DEPTH*BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]        count_q, count_d, remain;

  always_comb begin
    remain = count_q - CNT_W'(pop_n);
    data_d = data_q >> (BYTE_W * int'(pop_n));
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= int'(remain) && i < int'(remain) + MAX_LANES) begin
          data_d[i*BYTE_W +: BYTE_W] = push_data[(i - int'(remain))*BYTE_W +: BYTE_W];
        end
      end
    end
    count_d = remain + (push ? CNT_W'(MAX_LANES) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign head  = data_q[MAX_LANES*BYTE_W-1:0];
  assign count = count_q;

endmodule

// File: rtl/dsi_lanes_distributor.sv
// Spreads the bonded 32-bit HS stream over 1..4 lanes; lane outputs are registered one clock after the emit decision.
// Emits only while lanes_ready is high; pops a word only when the remainder after this cycle's emission fits beside it.
module dsi_lanes_distributor
  import dsi_lanes_pkg::*;
#(
  parameter int BUF_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  dsi_lanes_distributor_if.slave  bus
);

  localparam int CNT_W = $clog2(BUF_BYTES + 1);

  state_t           state_q, state_d;
  logic [1:0]       lanes_q;
  logic [2:0]       lanes_n;
  logic [CNT_W-1:0] count;
  logic [31:0]      head;
  logic [2:0]       emit_n;
  logic             fetch;
  logic [31:0]      group;
  logic [31:0]      lane_data_q;
  logic [3:0]       lane_valid_q;
  logic             hs_q;

  assign lanes_n = {1'b0, lanes_q} + 3'd1;

  always_comb begin
    state_d = state_q;
    emit_n  = '0;
    fetch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_ready) begin
          fetch   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.lanes_ready && count >= CNT_W'(lanes_n)) emit_n = lanes_n;
        fetch = bus.in_ready && ((count - CNT_W'(emit_n)) <= CNT_W'(MAX_LANES));
        if (!bus.in_ready) state_d = DRAIN;
      end
      DRAIN: begin
        // A short tail goes out as a partial group rather than waiting for more bytes.
        if (bus.lanes_ready && count != '0) begin
          emit_n = (count >= CNT_W'(lanes_n)) ? lanes_n : 3'(count);
        end
        if (count == CNT_W'(emit_n)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) fetch = 1'b0;
  end

  always_comb begin
    group = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < int'(emit_n)) group[i*BYTE_W +: BYTE_W] = head[i*BYTE_W +: BYTE_W];
    end
  end

  lanes_byte_buffer #(
    .DEPTH (BUF_BYTES),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (fetch),
    .push_data (bus.in_data),
    .pop_n     (emit_n),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lanes_q      <= '0;
      lane_data_q  <= '0;
      lane_valid_q <= '0;
      hs_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) lanes_q <= bus.lanes_number;
      lane_valid_q <= lane_mask(emit_n);
      if (emit_n != '0) lane_data_q <= group;
      // Held across stalls while bytes remain; drops once the buffer is empty and nothing was emitted.
      hs_q <= (emit_n != '0) || (hs_q && count != '0);
    end
  end

  assign bus.in_read    = fetch;
  assign bus.lane_data  = lane_data_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.hs_active  = hs_q;

endmodule

// File: doc/dsi_lanes_distributor.md
Name: dsi_lanes_distributor

Overview:
- Downstream neighbour of the packet bonding stage in the DSI HS path.
- Pops the continuous 32-bit stream, which already carries ECC/CRC, and spreads its bytes across 1..4 DSI data lanes.
- Lane 0 always receives the earliest byte.
- Handles residue bytes when the lane count does not divide 4, and drains partial groups at end of burst with a per-lane valid mask for the per-lane serializers.

Parameters:
- MAX_LANES, 4, number of physical lanes; fixed at 4 in this revision.
- BUF_BYTES, 8, byte buffer depth; must be ≥ 2*MAX_LANES.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- lanes_number  in  2  active lanes minus 1 (0 = 1 lane .. 3 = 4 lanes); latched only in IDLE.
- in_data  in  32  show-ahead word from the bonder; byte0 = [7:0] is the earliest byte.
- in_ready  in  1  bonder has a word available on in_data.
- in_read  out  1  pop strobe; the word on in_data is consumed in this cycle.
- lanes_ready  in  1  serializers accept an emission this cycle.
- lane_data  out  32  byte i for lane i ([8i+7:8i]).
- lane_valid  out  4  per-lane byte valid.
- hs_active  out  1  high while a burst is being emitted.

Behaviour:
- Reset: all outputs 0, count = 0, state IDLE, buffer cleared. Reset mid-burst discards buffered bytes immediately; in_read is 0 during reset.
- L = latched lanes_number + 1. Buffer is a byte FIFO with fill count 0..8.
- Emit condition in RUN: lanes_ready=1 and count ≥ L.
  - Bytes 0..L-1 move to lanes 0..L-1; the buffer shifts down by L.
  - Result is registered: lane_data/lane_valid update on the next clock.
  - lane_valid = mask of L ones, LSB first.
  - Unused lanes carry data 0, valid 0.
- No-emit cycle: lane_valid = 0 next cycle; lane_data holds its previous value.
- Fetch condition: in_ready=1, state ∈ {IDLE, RUN}, and (count − emitted_this_cycle) ≤ 4.
  - in_read = that condition, combinational.
  - The word is appended after the remaining bytes in the same clock.
- Fetch and emit in the same cycle are legal and required. Sustained throughput is L bytes per cycle with no bubbles:
  - L=4: in_read every cycle.
  - L=3: 3 of 4 cycles.
  - L=2: every 2nd cycle.
  - L=1: every 4th cycle.
- States:
  - IDLE: count=0, hs_active=0. Latch lanes_number. On in_ready, fetch and go to RUN.
  - RUN: fetch and emit as above. If in_ready=0 in a cycle where no fetch occurs, go to DRAIN.
  - DRAIN: no fetch; in_ready is ignored.
    - If count ≥ L, emit a full group.
    - If 0 < count < L and lanes_ready=1, emit count bytes on lanes 0..count-1, mask = (1<<count)−1.
    - When count reaches 0, go to IDLE.
- hs_active:
  - Rises together with the first registered lane_valid≠0.
  - Stays high through lanes_ready stalls.
  - Falls the cycle after the last drain emission appears.
- lanes_number changes outside IDLE are ignored.
- Count never exceeds 8; the fetch rule guarantees this. A bench assertion must check it.

Decomposition:
- Package dsi_lanes_pkg holds: state enum (IDLE, RUN, DRAIN), MAX_LANES, BYTE_W=8, and the function lane_mask(n) returning the 4-bit mask.
- One sub-module, lanes_byte_buffer: 8-byte shift buffer with count, a push of 4 bytes and a pop of n bytes in the same cycle.
- The FSM and output registers stay in the top level.

Test Plan:
- L=4, words 0x03020100, 0x07060504 back-to-back, lanes_ready=1 -> in_read high 2 consecutive cycles; lane_data 0x03020100 then 0x07060504, lane_valid 0xF, 0xF; hs_active falls one cycle after.
- L=3, words 0x03020100, 0x07060504, 0x0B0A0908 -> groups {00,01,02}, {03,04,05}, {06,07,08}, {09,0A,0B} on lanes 0..2, valid 0x7; in_read pattern 1,1,1,0; no bubble.
- L=3, single word 0x44332211 then in_ready=0 -> lanes {11,22,33} valid 0x7, next cycle lane0=44 valid 0x1; then IDLE.
- L=2, lanes_ready=0 for 3 cycles mid-burst -> lane_valid 0 during the stall, no byte lost or duplicated, hs_active stays 1, in_read stops once count would exceed 8.
- lanes_number changed 3→0 mid-burst -> ignored until IDLE; the next burst uses 1 lane with in_read every 4th cycle.
- reset asserted with count=5 in RUN -> next cycle all outputs 0, state IDLE; the following word emits from byte0.
